// File: rtl/ahb_sram_sub.sv
// AHB subordinate driving a single-port synchronous SRAM macro.
// Optional wait states before each access; two-cycle ERROR response for illegal transfers.
module ahb_sram_sub #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  hclk_i,
    input  logic                  hrst_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic [2:0]            hsize_i,
    input  logic                  hwrite_i,
    input  logic                  hready_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic [STRB_WIDTH-1:0] hwstrb_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [STRB_WIDTH-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int SW = $clog2(STRB_WIDTH);
    localparam int AW_KEEP = MEM_AW + SW;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_WR, S_RD_REQ, S_RD_DATA, S_ERR1, S_ERR2
    } state_t;

    state_t               state_q, state_d;
    logic [AW_KEEP-1:0]   addr_q, addr_d;
    logic [2:0]           size_q, size_d;
    logic                 write_q, write_d;
    logic [3:0]           cnt_q, cnt_d;

    logic                 final_cycle;
    logic                 accept;
    logic                 accept_err;
    state_t               accept_state;
    logic [4:0]           lane_off;
    logic [4:0]           lane_bytes;
    logic [STRB_WIDTH-1:0] lane_mask;

    // A new address phase is only taken while the current data phase is completing.
    assign final_cycle = (state_q == S_IDLE) || (state_q == S_WR) ||
                         (state_q == S_RD_DATA) || (state_q == S_ERR2);
    assign accept = hsel_i && (htrans_i == 2'b10 || htrans_i == 2'b11) && hready_i && final_cycle;

    assign accept_err = (hsize_i > 3'(SW)) ||
                        ((haddr_i & ((ADDR_WIDTH'(1) << hsize_i) - ADDR_WIDTH'(1))) != '0) ||
                        ((haddr_i >> SW) >= ADDR_WIDTH'(MEM_DEPTH));

    always_comb begin
        accept_state = S_ERR1;
        if (!accept_err) begin
            if (WAIT_STATES > 0) accept_state = S_WAIT;
            else if (hwrite_i)   accept_state = S_WR;
            else                 accept_state = S_RD_REQ;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        if (accept) begin
            addr_d  = haddr_i[AW_KEEP-1:0];
            size_d  = hsize_i;
            write_d = hwrite_i;
            cnt_d   = WAIT_LOAD;
        end
        unique case (state_q)
            S_IDLE, S_WR, S_RD_DATA, S_ERR2: state_d = accept ? accept_state : S_IDLE;
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = write_q ? S_WR : S_RD_REQ;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RD_REQ: state_d = S_RD_DATA;
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk_i or posedge hrst_i) begin
        if (hrst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte lanes covered by the registered size/address, ANDed with the bus strobes.
    assign lane_off   = 5'(addr_q[SW-1:0]);
    assign lane_bytes = 5'd1 << size_q;

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            assign lane_mask[gi] = (5'(gi) >= lane_off) && (5'(gi) < lane_off + lane_bytes);
        end
    endgenerate

    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        hrdata_o    = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        unique case (state_q)
            S_WAIT: hreadyout_o = 1'b0;
            S_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_wdata_o = hwdata_i;
                mem_be_o    = hwstrb_i & lane_mask;
            end
            S_RD_REQ: begin
                mem_req_o   = 1'b1;
                hreadyout_o = 1'b0;
            end
            S_RD_DATA: hrdata_o = mem_rdata_i;
            S_ERR1: begin
                hresp_o     = 1'b1;
                hreadyout_o = 1'b0;
            end
            S_ERR2:  hresp_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr_o = addr_q[AW_KEEP-1:SW];

endmodule
